wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Arbitrates the single register-file write port between two writeback requesters: req0 = ALU result path, req1 = load-data path.
- Uses round-robin selection and a valid/ready handshake per requester.
- Drives the 5-bit destination-register select and the 32-bit write data through one registered stage into the register file.
- Sits between the execute/memory stages and the register file; `grant_sel` is the select for the destination-address and data muxes.

Parameters:
- ADDR_W, 5, register address width
- DATA_W, 32, write data width
- CNT_W, 8, width of the saturating conflict counter

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- hold  input  1  stall from hazard unit; when 1 no grant is issued
- req0_valid  input  1  ALU writeback request
- req0_addr  input  ADDR_W  ALU destination register
- req0_data  input  DATA_W  ALU result
- req0_ready  output  1  ALU request accepted this cycle
- req1_valid  input  1  load writeback request
- req1_addr  input  ADDR_W  load destination register
- req1_data  input  DATA_W  load data
- req1_ready  output  1  load request accepted this cycle
- wr_en  output  1  register-file write enable (registered)
- wr_addr  output  ADDR_W  register-file write address (registered)
- wr_data  output  DATA_W  register-file write data (registered)
- grant_sel  output  1  source of the current wr_* values: 0 = req0, 1 = req1 (registered)
- conflict_cnt  output  CNT_W  saturating count of cycles with both requests valid and not held

Behaviour:
- Reset (rst=1 at a clock edge) clears these registers to 0: wr_en, wr_addr, wr_data, grant_sel, conflict_cnt.
- Reset sets last_grant=1, so req0 wins the first contention after reset.
- While rst=1, req0_ready and req1_ready are forced to 0. No handshake completes in a reset cycle, and a write registered in the previous cycle is discarded, not retried.
- Handshake: a transfer occurs on reqN when reqN_valid and reqN_ready are both 1 at a rising edge.
  - ready is combinational from the current valids, hold, rst and last_grant.
  - Requesters hold valid/addr/data stable until accepted.
- Grant rules, evaluated each cycle with rst=0 and hold=0:
  - only req0 valid -> grant 0.
  - only req1 valid -> grant 1.
  - both valid -> grant the port that is not last_grant.
  - none valid -> no grant.
- At most one ready is 1 per cycle (one-hot or zero).
- hold=1: both ready=0, last_grant unchanged, wr_en=0 next cycle, conflict_cnt unchanged.
- last_grant updates to the granted port only on a completed transfer.
- Latency: a transfer at edge k produces wr_en=1 with the matching wr_addr, wr_data and grant_sel during cycle k+1 (1 cycle). With no transfer, wr_en=0 next cycle, and wr_addr/wr_data/grant_sel hold their last values.
- Register 0: a transfer with addr==0 is accepted (ready asserted, pointer updates) but produces wr_en=0. wr_addr, wr_data and grant_sel still update.
- Same address from both ports in one cycle: there is no merging. The winner is written first and the loser the next cycle, so the loser's data is the final register value.
- Fairness: with both valid continuously, grants alternate 0,1,0,1…, and no port waits more than 1 cycle.
- conflict_cnt increments by 1 on each cycle with req0_valid & req1_valid & !hold & !rst, and saturates at 2^CNT_W−1 (255 by default) without wrapping.
- Throughput: 1 write per cycle maximum.
- No FSM beyond the last_grant flag, the output register stage and the counter.

Decomposition:
- Shared package/header:
  - ADDR_W and DATA_W defaults.
  - Port-index constants PORT_ALU=0 and PORT_LOAD=1.
  - Constant REG_ZERO=5'd0.
- One sub-module, rr_arb2: 2-input round-robin grant logic holding the last_grant register. Inputs are the valids, hold, rst and accept; outputs are the one-hot grant.
- The top level holds the output register stage, the zero-register suppression and the conflict counter.

Test Plan:
- Reset then a single request: rst 2 cycles, then req0 valid, addr=5'd3, data=32'hDEADBEEF. Expect req0_ready=1 same cycle; next cycle wr_en=1, wr_addr=3, wr_data=DEADBEEF, grant_sel=0. All outputs are 0 during reset.
- Continuous contention: both valid for 4 cycles, req0 addr=1 and req1 addr=2, each port re-presenting after acceptance. Expect grant order 0,1,0,1, wr_addr sequence 1,2,1,2, and conflict_cnt=4.
- Zero-register drop: req1 valid, addr=0, data=32'h1234. Expect req1_ready=1; next cycle wr_en=0, grant_sel=1; last_grant=1, so a following contention grants req0.
- Hold: both valid with hold=1 for 3 cycles. Expect both ready=0, wr_en=0 and conflict_cnt unchanged. After hold drops, the grant follows the pre-hold last_grant.
- Same address conflict: req0 addr=7 data=A and req1 addr=7 data=B with last_grant=1. Expect a write of A, then B on the next cycle.
- Reset mid-operation: rst asserted the cycle after a transfer. Expect wr_en=0 in the following cycle and the ready signals low. Also force conflict_cnt to 255 with continuous contention and check it saturates, staying at 255.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// +----------------------------------------------------------------------+
// | wb_port_arbiter_pkg : shared constants for the writeback arbiter     |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package wb_port_arbiter_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 8;

  localparam logic PORT_ALU  = 1'b0;
  localparam logic PORT_LOAD = 1'b1;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

`default_nettype wire

// File: rtl/wb_port_arbiter_if.sv
// +----------------------------------------------------------------------+
// | wb_port_arbiter_if : requester/register-file bundle of the arbiter   |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface wb_port_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
);
  logic              hold;
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              grant_sel;
  logic [CNT_W-1:0]  conflict_cnt;

  // Requester / stimulus side
  modport master (
    output hold,
    output req0_valid, req0_addr, req0_data,
    input  req0_ready,
    output req1_valid, req1_addr, req1_data,
    input  req1_ready,
    input  wr_en, wr_addr, wr_data, grant_sel, conflict_cnt
  );

  // Arbiter side
  modport slave (
    input  hold,
    input  req0_valid, req0_addr, req0_data,
    output req0_ready,
    input  req1_valid, req1_addr, req1_data,
    output req1_ready,
    output wr_en, wr_addr, wr_data, grant_sel, conflict_cnt
  );
endinterface

`default_nettype wire

// File: rtl/wb_port_arbiter_rr_arb2.sv
// +----------------------------------------------------------------------+
// | rr_arb2 : two-input round-robin grant with last-grant pointer        |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_arb2
  import wb_port_arbiter_pkg::*;
(
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       hold,
  input  wire logic [1:0] valid,
  input  wire logic       accept,
  output logic      [1:0] grant
);

  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    grant = 2'b00;
    if (!rst && !hold) begin
      unique case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        // Contention: the port that did not win last time goes now
        2'b11:   grant = (last_grant_q == PORT_LOAD) ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (accept) begin
      last_grant_d = grant[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= PORT_LOAD;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/wb_port_arbiter.sv
// +----------------------------------------------------------------------+
// | wb_port_arbiter : round-robin arbitration of the register-file write |
// | port between the ALU and load writeback paths. rev 1.0               |
// +----------------------------------------------------------------------+
`default_nettype none

module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input wire logic         clk,
  input wire logic         rst,
  wb_port_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]        valid;
  logic [1:0]        grant;
  logic              xfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  logic              wr_en_q,        wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q,      wr_addr_d;
  logic [DATA_W-1:0] wr_data_q,      wr_data_d;
  logic              grant_sel_q,    grant_sel_d;
  logic [CNT_W-1:0]  conflict_cnt_q, conflict_cnt_d;

  assign valid = {bus.req1_valid, bus.req0_valid};

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .rst    (rst),
    .hold   (bus.hold),
    .valid  (valid),
    .accept (xfer),
    .grant  (grant)
  );

  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];

  assign xfer     = |(valid & grant);
  assign sel_addr = grant[1] ? bus.req1_addr : bus.req0_addr;
  assign sel_data = grant[1] ? bus.req1_data : bus.req0_data;

  always_comb begin
    wr_en_d        = 1'b0;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    grant_sel_d    = grant_sel_q;
    conflict_cnt_d = conflict_cnt_q;
    if (xfer) begin
      // Writes to the hard-wired zero register are accepted but dropped
      wr_en_d     = (sel_addr != ADDR_W'(REG_ZERO));
      wr_addr_d   = sel_addr;
      wr_data_d   = sel_data;
      grant_sel_d = grant[1] ? PORT_LOAD : PORT_ALU;
    end
    if (bus.req0_valid && bus.req1_valid && !bus.hold && !rst &&
        (conflict_cnt_q != CNT_MAX)) begin
      conflict_cnt_d = conflict_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q        <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      grant_sel_q    <= 1'b0;
      conflict_cnt_q <= '0;
    end else begin
      wr_en_q        <= wr_en_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      grant_sel_q    <= grant_sel_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign bus.wr_en        = wr_en_q;
  assign bus.wr_addr      = wr_addr_q;
  assign bus.wr_data      = wr_data_q;
  assign bus.grant_sel    = grant_sel_q;
  assign bus.conflict_cnt = conflict_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_wb_port_arbiter : directed scoreboard bench for wb_port_arbiter   |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_wb_port_arbiter;

  typedef struct {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        sel;
    logic [7:0]  cnt;
  } exp_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  exp_t exp_q[$];

  wb_port_arbiter_if #(.ADDR_W(5), .DATA_W(32), .CNT_W(8)) bus ();

  wb_port_arbiter #(.ADDR_W(5), .DATA_W(32), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every registered output snapshot is compared against the queue head
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if (bus.wr_en !== e.en || bus.wr_addr !== e.addr || bus.wr_data !== e.data ||
            bus.grant_sel !== e.sel || bus.conflict_cnt !== e.cnt) begin
          n_fail++;
          $display("FAIL outputs @%0t: got en=%0b addr=%0d data=%08h sel=%0b cnt=%0d, want en=%0b addr=%0d data=%08h sel=%0b cnt=%0d",
                   $time, bus.wr_en, bus.wr_addr, bus.wr_data, bus.grant_sel, bus.conflict_cnt,
                   e.en, e.addr, e.data, e.sel, e.cnt);
        end
      end
    end
  end

  task automatic step(input logic r, input logic h,
                      input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                      input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                      input logic er0, input logic er1,
                      input logic een, input logic [4:0] eaddr, input logic [31:0] edata,
                      input logic esel, input logic [7:0] ecnt);
    exp_t e;
    @(negedge clk);
    rst            = r;
    bus.hold       = h;
    bus.req0_valid = v0;
    bus.req0_addr  = a0;
    bus.req0_data  = d0;
    bus.req1_valid = v1;
    bus.req1_addr  = a1;
    bus.req1_data  = d1;
    #1;
    n_tests++;
    if (bus.req0_ready !== er0 || bus.req1_ready !== er1) begin
      n_fail++;
      $display("FAIL ready @%0t: got r0=%0b r1=%0b, want r0=%0b r1=%0b",
               $time, bus.req0_ready, bus.req1_ready, er0, er1);
    end
    e.en = een; e.addr = eaddr; e.data = edata; e.sel = esel; e.cnt = ecnt;
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst            = 1'b1;
    bus.hold       = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req0_addr  = '0;
    bus.req0_data  = '0;
    bus.req1_valid = 1'b0;
    bus.req1_addr  = '0;
    bus.req1_data  = '0;

    // Reset, then a single ALU write
    step(1,0, 0,5'd0,32'h0,          0,5'd0,32'h0,     0,0, 0,5'd0,32'h0,        0,8'd0);
    step(1,0, 0,5'd0,32'h0,          0,5'd0,32'h0,     0,0, 0,5'd0,32'h0,        0,8'd0);
    step(0,0, 1,5'd3,32'hDEADBEEF,   0,5'd0,32'h0,     1,0, 1,5'd3,32'hDEADBEEF, 0,8'd0);
    step(0,0, 0,5'd3,32'hDEADBEEF,   0,5'd0,32'h0,     0,0, 0,5'd3,32'hDEADBEEF, 0,8'd0);
    // Lone load write leaves last_grant=1
    step(0,0, 0,5'd0,32'h0,          1,5'd9,32'h99,    0,1, 1,5'd9,32'h99,       1,8'd0);
    // Continuous contention: 0,1,0,1
    step(0,0, 1,5'd1,32'h11,         1,5'd2,32'h22,    1,0, 1,5'd1,32'h11,       0,8'd1);
    step(0,0, 1,5'd1,32'h11,         1,5'd2,32'h22,    0,1, 1,5'd2,32'h22,       1,8'd2);
    step(0,0, 1,5'd1,32'h11,         1,5'd2,32'h22,    1,0, 1,5'd1,32'h11,       0,8'd3);
    step(0,0, 1,5'd1,32'h11,         1,5'd2,32'h22,    0,1, 1,5'd2,32'h22,       1,8'd4);
    // Zero register: accepted, no write enable
    step(0,0, 0,5'd0,32'h0,          1,5'd0,32'h1234,  0,1, 0,5'd0,32'h1234,     1,8'd4);
    step(0,0, 1,5'd4,32'h44,         1,5'd5,32'h55,    1,0, 1,5'd4,32'h44,       0,8'd5);
    // Hold with both valid
    step(0,1, 1,5'd4,32'h44,         1,5'd5,32'h55,    0,0, 0,5'd4,32'h44,       0,8'd5);
    step(0,1, 1,5'd4,32'h44,         1,5'd5,32'h55,    0,0, 0,5'd4,32'h44,       0,8'd5);
    step(0,1, 1,5'd4,32'h44,         1,5'd5,32'h55,    0,0, 0,5'd4,32'h44,       0,8'd5);
    step(0,0, 1,5'd4,32'h44,         1,5'd5,32'h55,    0,1, 1,5'd5,32'h55,       1,8'd6);
    // Same destination from both ports: A then B
    step(0,0, 1,5'd7,32'hAAAA0001,   1,5'd7,32'hBBBB0002, 1,0, 1,5'd7,32'hAAAA0001, 0,8'd7);
    step(0,0, 0,5'd7,32'h0,          1,5'd7,32'hBBBB0002, 0,1, 1,5'd7,32'hBBBB0002, 1,8'd7);
    // Reset right after a transfer
    step(0,0, 1,5'd8,32'h88,         0,5'd0,32'h0,     1,0, 1,5'd8,32'h88,       0,8'd7);
    step(1,0, 1,5'd9,32'h90,         1,5'd10,32'hA0,   0,0, 0,5'd0,32'h0,        0,8'd0);
    step(0,0, 0,5'd0,32'h0,          0,5'd0,32'h0,     0,0, 0,5'd0,32'h0,        0,8'd0);
    // Saturation: last_grant=1 after reset, so even cycles grant req0
    for (int i = 0; i < 258; i++) begin
      if (i % 2 == 0)
        step(0,0, 1,5'd1,32'h11, 1,5'd2,32'h22, 1,0, 1,5'd1,32'h11, 0, (i >= 254) ? 8'd255 : 8'(i + 1));
      else
        step(0,0, 1,5'd1,32'h11, 1,5'd2,32'h22, 0,1, 1,5'd2,32'h22, 1, (i >= 254) ? 8'd255 : 8'(i + 1));
    end
    step(0,0, 0,5'd0,32'h0,          0,5'd0,32'h0,     0,0, 0,5'd2,32'h22,       1,8'd255);

    #10;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
